// File: rtl/lcd_hex_frame_builder.sv
// Builds a 32-char two-line ASCII hex frame for the 16x2 LCD driver.
// Optional: define LCD_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module lcd_hex_frame_builder #(
    parameter logic [31:0] LABEL_A        = "PC  ",
    parameter logic [31:0] LABEL_B        = "INST",
    parameter int unsigned REFRESH_CYCLES = 0
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [31:0]  WORD_A,
    input  logic [31:0]  WORD_B,
    input  logic         UPDATE,
    output logic         BUSY,
    output logic         FRAME_DONE,
    output logic [255:0] MP_OUT
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam bit          REF_EN = (REFRESH_CYCLES != 0);
    localparam logic [23:0] RELOAD = 24'(REFRESH_CYCLES - 1);
    localparam logic [23:0] SP3    = 24'h202020;
    localparam logic [7:0]  COLON  = 8'h3A;

    state_t         state_q;
    logic [3:0]     idx_q;
    logic           pend_q;
    logic [31:0]    snap_a_q;
    logic [31:0]    snap_b_q;
    logic [127:0]   shadow_q;
    logic [23:0]    cnt_q;
    logic [23:0]    cnt_d;
    logic           tick;
    logic           req;
    logic [31:0]    word;
    logic [3:0]     nib;
    logic [7:0]     hex;
    logic [7:0]     digit_d;
    logic [255:0]   frame_d;
`ifdef LCD_LEADING_ZERO_BLANK_EN
    logic           nz_q;
    logic           nz_d;
    logic           seen;
`endif

    // Free-running refresh counter and periodic request tick
    always_comb begin
        tick  = REF_EN && (cnt_q == RELOAD);
        cnt_d = tick ? 24'd0 : cnt_q + 24'd1;
        req   = UPDATE | tick;
    end

    // Encode the snapshot nibble selected by idx into one ASCII digit
    always_comb begin
        word = idx_q[3] ? snap_b_q : snap_a_q;
        nib  = 4'(word >> {3'd7 - idx_q[2:0], 2'b00});
        if (nib < 4'd10)
            hex = 8'h30 + {4'h0, nib};
        else
            hex = 8'h37 + {4'h0, nib};
`ifdef LCD_LEADING_ZERO_BLANK_EN
        seen = (idx_q[2:0] == 3'd0) ? 1'b0 : nz_q;
        nz_d = seen | (nib != 4'd0);
        if (!seen && (nib == 4'd0) && (idx_q[2:0] != 3'd7))
            digit_d = 8'h20;
        else
            digit_d = hex;
`else
        digit_d = hex;
`endif
    end

    // Labels, colons and trailing spaces are constant, so only digits are shadowed
    always_comb begin
        frame_d = {LABEL_A, COLON, shadow_q[127:64], SP3,
                   LABEL_B, COLON, shadow_q[63:0],   SP3};
    end

    // Capture / convert / commit sequencer with registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            pend_q     <= 1'b0;
            snap_a_q   <= 32'd0;
            snap_b_q   <= 32'd0;
            shadow_q   <= '0;
            cnt_q      <= 24'd0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
            MP_OUT     <= {32{8'h20}};
`ifdef LCD_LEADING_ZERO_BLANK_EN
            nz_q       <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            FRAME_DONE <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        snap_a_q <= WORD_A;
                        snap_b_q <= WORD_B;
                        idx_q    <= 4'd0;
                        BUSY     <= 1'b1;
                        state_q  <= CONVERT;
                    end
                end
                CONVERT: begin
                    shadow_q[{~idx_q, 3'b000} +: 8] <= digit_d;
`ifdef LCD_LEADING_ZERO_BLANK_EN
                    nz_q <= nz_d;
`endif
                    if (req)
                        pend_q <= 1'b1;
                    if (idx_q == 4'd15)
                        state_q <= COMMIT;
                    else
                        idx_q <= idx_q + 4'd1;
                end
                COMMIT: begin
                    MP_OUT     <= frame_d;
                    FRAME_DONE <= 1'b1;
                    // A request landing on this edge is served right away
                    if (pend_q || req) begin
                        pend_q   <= 1'b0;
                        snap_a_q <= WORD_A;
                        snap_b_q <= WORD_B;
                        idx_q    <= 4'd0;
                        state_q  <= CONVERT;
                    end else begin
                        BUSY    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
